hdc_perf_monitor: RTL

- Synthesizable, passive performance and accuracy monitor that sits beside hdc_sensor_fusion on chip.
- It snoops the fin and dout valid/ready handshakes and never drives them.
- It counts handshake stall conditions, timestamps each accepted input in a FIFO, and measures per-entry latency (total/min/max).
- It counts label mismatches against an expected-label input. This lets silicon report the same statistics the gate-level bench computes.

---
 rtl/hdc_perf_pkg.sv | 17 +
 rtl/hdc_ts_fifo.sv | 43 ++++
 rtl/hdc_perf_monitor.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hdc_perf_pkg.sv
// Shared types, constants and saturating arithmetic for the HDC performance monitor.
package hdc_perf_pkg;

  localparam int PERF_CNT_W = 32;

  typedef logic [PERF_CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX      = '1;
  localparam cnt_t LAT_MIN_INIT = '1;

  function automatic cnt_t sat_add(input cnt_t a, input cnt_t b);
    logic [PERF_CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PERF_CNT_W] ? CNT_MAX : s[PERF_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/hdc_ts_fifo.sv
// Timestamp FIFO: one extra pointer bit separates full from empty; push and pop may coincide.
module hdc_ts_fifo
  import hdc_perf_pkg::*;
#(
  parameter int W     = PERF_CNT_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hdc_perf_monitor.sv
// Passive monitor snooping the fin/dout handshakes of hdc_sensor_fusion: stalls, latency, label errors.
// Handshakes: a transfer happens in a cycle where valid & ready are both high; this block only observes them.
module hdc_perf_monitor
  import hdc_perf_pkg::*;
#(
  parameter int NUM_LABELS   = 2,
  parameter int DEPTH        = 4,
  parameter int CNT_WIDTH    = PERF_CNT_W,
  parameter int SKIP_ENTRIES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  fin_valid,
  input  logic                  fin_ready,
  input  logic                  dout_valid,
  input  logic                  dout_ready,
  input  logic [NUM_LABELS-1:0] dout_label,
  input  logic [NUM_LABELS-1:0] exp_label,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  fin_stall_cnt,
  output logic [CNT_WIDTH-1:0]  fin_idle_cnt,
  output logic [CNT_WIDTH-1:0]  dout_stall_cnt,
  output logic [CNT_WIDTH-1:0]  dout_idle_cnt,
  output logic [CNT_WIDTH-1:0]  in_count,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic [CNT_WIDTH-1:0]  lat_total,
  output logic [CNT_WIDTH-1:0]  lat_min,
  output logic [CNT_WIDTH-1:0]  lat_max,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  typedef logic [CNT_WIDTH-1:0] ctr_t;

  localparam ctr_t ONE      = ctr_t'(1);
  localparam ctr_t SKIP_THR = ctr_t'(SKIP_ENTRIES);

  function automatic ctr_t sat_sum(input ctr_t a, input ctr_t b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  logic flush;
  logic push, pop, push_ok, pop_ok;
  logic full, empty;
  ctr_t head_ts, latency, mis_bits;

  assign flush = rst | clear;
  assign push  = enable & fin_valid & fin_ready;
  assign pop   = enable & dout_valid & dout_ready;

  // A pop from a full FIFO frees the slot the coincident push needs.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Modular subtraction keeps latency correct across cycle_count wrap.
  assign latency = cycle_count - head_ts;

  always_comb begin
    mis_bits = '0;
    for (int i = 0; i < NUM_LABELS; i++) begin
      mis_bits = mis_bits + ctr_t'(dout_label[i] ^ exp_label[i]);
    end
  end

  hdc_ts_fifo #(
    .W     (CNT_WIDTH),
    .DEPTH (DEPTH)
  ) u_ts_fifo (
    .clk   (clk),
    .rst   (flush),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (cycle_count),
    .dout  (head_ts),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      cycle_count    <= '0;
      fin_stall_cnt  <= '0;
      fin_idle_cnt   <= '0;
      dout_stall_cnt <= '0;
      dout_idle_cnt  <= '0;
      in_count       <= '0;
      out_count      <= '0;
      lat_total      <= '0;
      lat_min        <= '1;
      lat_max        <= '0;
      mismatch_cnt   <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else if (enable) begin
      cycle_count <= cycle_count + ONE;

      if (fin_valid && !fin_ready)   fin_stall_cnt  <= sat_sum(fin_stall_cnt, ONE);
      if (!fin_valid && fin_ready)   fin_idle_cnt   <= sat_sum(fin_idle_cnt, ONE);
      if (dout_valid && !dout_ready) dout_stall_cnt <= sat_sum(dout_stall_cnt, ONE);
      if (!dout_valid && dout_ready) dout_idle_cnt  <= sat_sum(dout_idle_cnt, ONE);

      if (push_ok) in_count <= sat_sum(in_count, ONE);
      if (push && !push_ok) overflow <= 1'b1;

      if (pop) begin
        out_count <= sat_sum(out_count, ONE);
        if (out_count >= SKIP_THR) mismatch_cnt <= sat_sum(mismatch_cnt, mis_bits);
        if (pop_ok) begin
          lat_total <= sat_sum(lat_total, latency);
          if (latency < lat_min) lat_min <= latency;
          if (latency > lat_max) lat_max <= latency;
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule
